// File: rtl/seq_sort_calc.sv
// seq_sort_calc: captures a burst of DEPTH unsigned W-bit numbers plus a mode,
// then streams DEPTH signed W+2-bit results (ascending, descending, offset
// from first element, or delta from previous element).
// Optional build macro SEQ_SORT_CALC_ABS_EN: modes 10/11 output |difference|.
module seq_sort_calc #(
  parameter int W     = 4,
  parameter int DEPTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [W-1:0]        in_number,
  input  logic [1:0]          mode,
  output logic                out_valid,
  output logic signed [W+1:0] out_result
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]          r_state;
  logic [IW-1:0]       r_cnt;
  logic [IW-1:0]       r_oidx;
  logic [1:0]          r_mode;
  logic                r_out_valid;
  logic signed [W+1:0] r_out_result;
  logic [W-1:0]        r_raw [DEPTH];
  logic [W-1:0]        r_srt [DEPTH];

  logic [W-1:0]        w_raw_nxt [DEPTH];
  logic [W-1:0]        w_srt_nxt [DEPTH];
  logic [DEPTH-1:0]    w_le;
  logic                w_wr;
  logic                w_last;
  logic [IW-1:0]       w_oi;
  logic [IW-1:0]       w_ri;
  logic [IW-1:0]       w_pi;
  logic signed [W+1:0] w_res;

  // Zero-extended difference a-b; the W+2 width cannot overflow.
  function automatic logic signed [W+1:0] f_sub(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic signed [W+1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
`ifdef SEQ_SORT_CALC_ABS_EN
    if (d < 0) d = -d;
`endif
    return d;
  endfunction

  assign w_wr   = in_valid && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_last = in_valid && (r_state == S_LOAD) && (r_cnt == IW'(DEPTH - 1));
  // Index of the result to register this cycle: 0 on the last beat, else next.
  assign w_oi   = ((r_state == S_OUT) && (r_oidx != IW'(DEPTH - 1))) ?
                  r_oidx + IW'(1) : '0;
  assign w_ri   = IW'(DEPTH - 1) - w_oi;
  assign w_pi   = (w_oi == '0) ? '0 : w_oi - IW'(1);

  // Next buffer contents: raw append plus one-step stable insertion into the
  // sorted buffer (new value lands after every stored element <= it).
  always_comb begin
    w_raw_nxt = r_raw;
    w_srt_nxt = r_srt;
    w_le      = '0;
    for (int j = 0; j < DEPTH; j++)
      w_le[j] = (IW'(j) < r_cnt) && (r_srt[j] <= in_number);
    if (w_wr) begin
      w_raw_nxt[r_cnt] = in_number;
      if (!w_le[0]) w_srt_nxt[0] = in_number;
      for (int j = 1; j < DEPTH; j++) begin
        if (!w_le[j]) w_srt_nxt[j] = w_le[j-1] ? in_number : r_srt[j-1];
      end
    end
  end

  // Result selection, computed from next buffers so the last beat is visible.
  always_comb begin
    w_res = '0;
    case (r_mode)
      2'b00:   w_res = $signed({2'b00, w_srt_nxt[w_oi]});
      2'b01:   w_res = $signed({2'b00, w_srt_nxt[w_ri]});
      2'b10:   w_res = f_sub(w_raw_nxt[w_oi], w_raw_nxt[0]);
      default: w_res = (w_oi == '0) ? $signed({2'b00, w_raw_nxt[0]}) :
                       f_sub(w_raw_nxt[w_oi], w_raw_nxt[w_pi]);
    endcase
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_raw[j] <= '0;
        r_srt[j] <= '0;
      end
    end else begin
      r_raw <= w_raw_nxt;
      r_srt <= w_srt_nxt;
    end
  end

  // Control FSM and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_oidx       <= '0;
      r_mode       <= 2'b00;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid  <= 1'b0;
          r_out_result <= '0;
          if (in_valid) begin
            r_mode  <= mode;
            r_cnt   <= IW'(1);
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!in_valid) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_cnt        <= '0;
            r_oidx       <= '0;
            r_out_valid  <= 1'b1;
            r_out_result <= w_res;
            r_state      <= S_OUT;
          end else begin
            r_cnt <= r_cnt + IW'(1);
          end
        end
        S_OUT: begin
          if (r_oidx == IW'(DEPTH - 1)) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_oidx       <= r_oidx + IW'(1);
            r_out_result <= w_res;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_out_valid  <= 1'b0;
          r_out_result <= '0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;

endmodule
